// File: rtl/refclk_nco_gen_if.sv
// Trim request handshake and readback for the refclk NCO.
interface refclk_nco_gen_if;
  logic        i_trim_valid;
  logic [15:0] i_trim;
  logic        o_trim_ready;
  logic [15:0] o_trim_active;

  modport master (
    output i_trim_valid,
    output i_trim,
    input  o_trim_ready,
    input  o_trim_active
  );

  modport slave (
    input  i_trim_valid,
    input  i_trim,
    output o_trim_ready,
    output o_trim_active
  );
endinterface

// File: rtl/refclk_nco_gen.sv
// Phase-accumulator NCO producing a ~32.768 kHz reference clock with a
// signed frequency trim that is applied only at a period boundary.
module refclk_nco_gen #(
  parameter int unsigned SYS_CLK_HZ = 10_000_000,
  parameter int unsigned REF_CLK_HZ = 32_768,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  refclk_nco_gen_if.slave   trim_if,
  output logic              o_refclk,
  output logic              o_refclk_stb
);

  localparam int unsigned W  = ACC_WIDTH;
  localparam int unsigned TW = 16;
  // Wide enough for any trim value so the clamp never sees a wrapped sum.
  localparam int unsigned SW = (W + 2 > TW + 2) ? W + 2 : TW + 2;

  localparam logic [63:0] INC_NOM =
    ((64'(REF_CLK_HZ) << W) + 64'(SYS_CLK_HZ / 2)) / 64'(SYS_CLK_HZ);
  localparam logic signed [SW-1:0] INC_NOM_S = signed'(SW'(INC_NOM));
  localparam logic signed [SW-1:0] INC_MIN   = signed'(SW'(1));
  localparam logic signed [SW-1:0] INC_MAX   = signed'(SW'((64'd1 << (W - 1)) - 64'd1));

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            stb_q, stb_d;
  logic            ready_q, ready_d;
  logic [TW-1:0]   pend_q, pend_d;
  logic [TW-1:0]   active_q, active_d;

  logic signed [SW-1:0] inc_sum;
  logic [W-1:0]         inc_eff;
  logic [W:0]           acc_sum;
  logic                 wrap;

  // Effective increment: nominal plus applied trim, clamped to [1, 2^(W-1)-1].
  always_comb begin
    inc_sum = INC_NOM_S + SW'(signed'(active_q));
    if (inc_sum < INC_MIN) begin
      inc_eff = W'(INC_MIN);
    end else if (inc_sum > INC_MAX) begin
      inc_eff = W'(INC_MAX);
    end else begin
      inc_eff = W'(inc_sum);
    end
    acc_sum = {1'b0, acc_q} + {1'b0, inc_eff};
    wrap    = i_en & acc_sum[W];
  end

  // Accumulator advance and trim hand-off state machine.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    stb_d    = 1'b0;
    pend_d   = pend_q;
    active_d = active_q;

    if (i_en) begin
      acc_d = acc_sum[W-1:0];
      stb_d = ~acc_q[W-1] & acc_sum[W-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (trim_if.i_trim_valid && ready_q) begin
          pend_d  = trim_if.i_trim;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (wrap) begin
          active_d = pend_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      stb_q    <= 1'b0;
      ready_q  <= 1'b1;
      pend_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      stb_q    <= stb_d;
      ready_q  <= ready_d;
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  assign o_refclk              = acc_q[W-1];
  assign o_refclk_stb          = stb_q;
  assign trim_if.o_trim_ready  = ready_q;
  assign trim_if.o_trim_active = active_q;

endmodule
